// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit arbiter and related shared-resource arbiters.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    HOLD = 2'd3
  } arb_state_t;

  // Index width that stays at least 1 bit wide for a single requester.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// Combinational round-robin pick: first valid index at or after the pointer, wrapping.
module rr_select
  import uart_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] i_req_valid,
  input  logic [IW-1:0]   i_rr_ptr,
  output logic [IW-1:0]   o_winner,
  output logic            o_any
);

  int idx;

  // Scan from the farthest offset down so the closest valid index is written last.
  always_comb begin
    o_winner = '0;
    o_any    = 1'b0;
    idx      = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = (int'(i_rr_ptr) + i) % NREQ;
      if (i_req_valid[idx]) begin
        o_winner = IW'(idx);
        o_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx among NREQ byte streams, with per-frame lock.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int WIDTH        = 8,
  parameter int HOLD_TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic [NREQ-1:0]       i_req_valid,
  input  logic [NREQ*WIDTH-1:0] i_req_data,
  input  logic [NREQ-1:0]       i_req_last,
  output logic [NREQ-1:0]       o_req_ready,
  output logic                  o_dv,
  output logic [WIDTH-1:0]      o_data,
  input  logic                  i_busy,
  output logic [NREQ-1:0]       o_grant,
  output logic                  o_active
);

  localparam int IW = idx_w(NREQ);
  localparam int CW = $clog2(HOLD_TIMEOUT + 1);

  arb_state_t       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [IW-1:0]    win;
  logic             any_v;
  logic [IW-1:0]    sel_idx;
  logic [IW-1:0]    ptr_next;
  logic             accept;
  logic [NREQ-1:0]  ready;
  logic [NREQ-1:0]  grant;

  rr_select #(.NREQ(NREQ), .IW(IW)) u_sel (
    .i_req_valid (i_req_valid),
    .i_rr_ptr    (ptr_q),
    .o_winner    (win),
    .o_any       (any_v)
  );

  assign ptr_next = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    last_d  = last_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ready   = '0;
    o_dv    = 1'b0;
    accept  = 1'b0;
    sel_idx = owner_q;
    case (state_q)
      IDLE: begin
        if (!i_busy && any_v) begin
          ready[win] = 1'b1;
          sel_idx    = win;
          accept     = 1'b1;
        end
      end
      LOAD: begin
        o_dv = 1'b1;
        if (i_busy) state_d = SEND;
      end
      SEND: begin
        if (!i_busy) begin
          if (last_q) begin
            state_d = IDLE;
            ptr_d   = ptr_next;
          end else begin
            state_d = HOLD;
            cnt_d   = '0;
          end
        end
      end
      HOLD: begin
        ready[owner_q] = 1'b1;
        // A byte arriving on the timeout cycle wins over the release.
        if (i_req_valid[owner_q]) begin
          accept = 1'b1;
        end else if (cnt_q == CW'(HOLD_TIMEOUT - 1)) begin
          state_d = IDLE;
          ptr_d   = ptr_next;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      state_d = LOAD;
      owner_d = sel_idx;
      data_d  = i_req_data[int'(sel_idx)*WIDTH +: WIDTH];
      last_d  = i_req_last[sel_idx];
    end
  end

  always_comb begin
    grant = '0;
    if (state_q != IDLE) grant[owner_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      last_q  <= 1'b0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_req_ready = i_reset ? '0 : ready;
  assign o_data      = data_q;
  assign o_grant     = grant;
  assign o_active    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural uart_tx, frame-level round-robin model, directed + random steps.
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int HT   = 8;
  localparam int DIV  = 4;

  logic              clk = 1'b0;
  logic              i_reset = 1'b1;
  logic [NREQ-1:0]   valid = '0, last = '0;
  logic [NREQ*W-1:0] data = '0;
  logic [NREQ-1:0]   ready, grant;
  logic              dv, busy, active;
  logic [W-1:0]      odata;

  uart_tx_arbiter #(.NREQ(NREQ), .WIDTH(W), .HOLD_TIMEOUT(HT)) dut (
    .clk(clk), .i_reset(i_reset), .i_req_valid(valid), .i_req_data(data),
    .i_req_last(last), .o_req_ready(ready), .o_dv(dv), .o_data(odata),
    .i_busy(busy), .o_grant(grant), .o_active(active)
  );

  always #5 clk = ~clk;

  // Transmitter stand-in: samples i_dv when idle, busy through start+data bits, then a stop bit.
  int          tx_cnt = 0;
  logic        force_busy = 1'b0;
  logic [7:0]  line_q[$];
  assign busy = force_busy || (tx_cnt > DIV);
  always @(posedge clk) begin
    if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
    else if (dv) begin
      tx_cnt <= 10 * DIV;
      line_q.push_back(odata);
    end
  end

  int nvec = 0, nerr = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Requester sources and frame-level model state.
  logic [7:0] mem[NREQ][64];
  logic       lmem[NREQ][64];
  int         blen[NREQ], bpos[NREQ], nfr[NREQ], mfr[NREQ], mpos[NREQ];
  int         flen[NREQ][32];
  int         m_ptr = 0;
  logic [7:0] exp_q[$];

  logic [NREQ-1:0] acc, last_rdy, last_acc, last_grant, grant_busy;
  logic            last_active, prev_dv = 1'b0, prev_acc_v = 1'b0;
  logic [7:0]      prev_data, prev_byte, acc_byte;
  int              rdy_cnt[NREQ];

  task automatic drive();
    for (int k = 0; k < NREQ; k++) begin
      valid[k] = bpos[k] < blen[k];
      data[k*W +: W] = valid[k] ? mem[k][bpos[k]] : 8'h00;
      last[k] = valid[k] ? lmem[k][bpos[k]] : 1'b0;
    end
  endtask

  task automatic add_frame(input int k, input int n, input logic [23:0] bs, input logic lf);
    for (int i = 0; i < n; i++) begin
      mem[k][blen[k]+i]  = bs[i*8 +: 8];
      lmem[k][blen[k]+i] = (i == n - 1) && lf;
    end
    blen[k] += n;
    flen[k][nfr[k]] = n;
    nfr[k]++;
    drive();
  endtask

  // Whole frames in round-robin order over requesters with pending frames.
  task automatic model_batch();
    int found;
    while (1) begin
      found = -1;
      for (int i = 0; i < NREQ; i++) begin
        int j;
        j = (m_ptr + i) % NREQ;
        if (found < 0 && mfr[j] < nfr[j]) found = j;
      end
      if (found < 0) break;
      for (int n = 0; n < flen[found][mfr[found]]; n++) begin
        exp_q.push_back(mem[found][mpos[found]]);
        mpos[found]++;
      end
      mfr[found]++;
      m_ptr = (found + 1) % NREQ;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    acc = valid & ready;
    chk("ready_onehot0", 32'($onehot0(ready)), 1);
    chk("grant_onehot0", 32'($onehot0(grant)), 1);
    chk("grant_vs_active", 32'(grant != '0), 32'(active));
    if (prev_acc_v) begin
      chk("accept_to_dv", 32'(dv), 1);
      chk("accept_data", 32'(odata), 32'(prev_byte));
    end
    if (dv && prev_dv) chk("dv_data_stable", 32'(odata), 32'(prev_data));
    acc_byte = 8'h00;
    for (int k = 0; k < NREQ; k++) begin
      rdy_cnt[k] += int'(ready[k]);
      if (acc[k]) acc_byte = mem[k][bpos[k]];
    end
    last_rdy = ready; last_acc = acc; last_grant = grant; last_active = active;
    if (busy && active) grant_busy = grant;
    prev_dv = dv; prev_data = odata;
    prev_acc_v = (acc != '0) && !i_reset;
    prev_byte = acc_byte;
    @(posedge clk); #1;
    if (!i_reset) for (int k = 0; k < NREQ; k++) if (acc[k]) bpos[k]++;
    drive();
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    m_ptr = 0;
  endtask

  task automatic finish_batch(input string tag);
    int  n;
    bit  pending;
    n = 0;
    do begin
      pending = 0;
      for (int k = 0; k < NREQ; k++) if (bpos[k] < blen[k]) pending = 1;
      pending = pending || active || (tx_cnt != 0);
      if (pending) begin tick(); n++; end
    end while (pending && n < 20000);
    chk({tag, "_done"}, 32'(pending), 0);
    chk({tag, "_count"}, line_q.size(), exp_q.size());
    while (line_q.size() > 0 && exp_q.size() > 0)
      chk({tag, "_byte"}, 32'(line_q.pop_front()), 32'(exp_q.pop_front()));
    line_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_for(input string tag, input int what);
    int n;
    n = 0;
    while (n < 200 && !((what == 0 && last_acc[0]) || (what == 1 && busy) ||
                        (what == 2 && !busy) || (what == 3 && last_acc[1]))) begin
      tick(); n++;
    end
    chk({tag, "_wait"}, 32'(n < 200), 1);
  endtask

  initial begin
    int n;
    for (int k = 0; k < NREQ; k++) begin
      blen[k] = 0; bpos[k] = 0; nfr[k] = 0; mfr[k] = 0; mpos[k] = 0; rdy_cnt[k] = 0;
    end
    last_acc = '0;
    do_reset();
    tick();
    do_reset();
    chk("rst_ready", 32'(ready), 0);
    chk("rst_dv", 32'(dv), 0);
    chk("rst_data", 32'(odata), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_active", 32'(active), 0);

    // Single byte from req1.
    for (int k = 0; k < NREQ; k++) rdy_cnt[k] = 0;
    grant_busy = '0;
    add_frame(1, 1, 24'h0000A5, 1'b1);
    model_batch();
    finish_batch("single");
    chk("single_ready_cycles", rdy_cnt[1], 1);
    chk("single_grant_busy", 32'(grant_busy), 32'b0010);
    chk("single_grant_end", 32'(last_grant), 0);

    // Contention, then a full round after the pointer wraps.
    do_reset();
    add_frame(0, 1, 24'h10, 1'b1);
    add_frame(2, 1, 24'h12, 1'b1);
    add_frame(3, 1, 24'h13, 1'b1);
    model_batch();
    finish_batch("contend");
    for (int k = 0; k < NREQ; k++) add_frame(k, 1, 24'(8'h20 + k), 1'b1);
    model_batch();
    finish_batch("round2");

    // Frame lock: req2 waits for the whole 3-byte frame from req1.
    add_frame(1, 3, 24'h030201, 1'b1);
    add_frame(2, 1, 24'h22, 1'b1);
    model_batch();
    finish_batch("lock");

    // Reset while a frame is on the line.
    add_frame(1, 1, 24'h77, 1'b1);
    model_batch();
    wait_for("rst_acc", 3);
    wait_for("rst_busy", 1);
    add_frame(0, 1, 24'h0F, 1'b1);
    tick(); tick();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    m_ptr = 0;
    model_batch();
    chk("midrst_ready", 32'(ready), 0);
    chk("midrst_dv", 32'(dv), 0);
    chk("midrst_data", 32'(odata), 0);
    chk("midrst_grant", 32'(grant), 0);
    chk("midrst_active", 32'(active), 0);
    n = 0;
    while (busy && n < 100) begin
      tick(); n++;
      chk("midrst_no_grant", 32'(last_rdy | last_grant), 0);
    end
    finish_batch("midrst");

    // Busy held in IDLE blocks the grant; release accepts the same cycle.
    force_busy = 1'b1;
    add_frame(2, 1, 24'hC2, 1'b1);
    model_batch();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_ready", 32'(last_rdy), 0);
      chk("stall_dv", 32'(dv), 0);
    end
    force_busy = 1'b0;
    tick();
    chk("stall_accept", 32'(last_acc), 32'b0100);
    finish_batch("stall");

    // Hold timeout: req0 leaves its frame open, req3 gets the line afterwards.
    do_reset();
    add_frame(0, 1, 24'h55, 1'b0);
    add_frame(3, 1, 24'h33, 1'b1);
    model_batch();
    wait_for("to_acc", 0);
    wait_for("to_busy", 1);
    wait_for("to_idle", 2);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (last_rdy[0]) n++;
      else if (n > 0) break;
    end
    chk("timeout_hold_cycles", n, HT);
    chk("timeout_next_ready", 32'(last_rdy), 32'b1000);
    chk("timeout_idle", 32'(last_active), 0);
    finish_batch("timeout");

    // Valid arriving in the final HOLD cycle is accepted instead of timing out.
    add_frame(0, 1, 24'h66, 1'b0);
    wait_for("late_acc", 0);
    wait_for("late_busy", 1);
    wait_for("late_idle", 2);
    n = 0;
    for (int i = 0; i < 40 && n < HT - 1; i++) begin
      tick();
      if (last_rdy[0]) n++;
    end
    chk("late_hold_cycles", n, HT - 1);
    add_frame(0, 1, 24'h67, 1'b1);
    tick();
    chk("late_valid_accept", 32'(last_acc), 32'b0001);
    model_batch();
    finish_batch("late");

    // Random frames across all requesters.
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < NREQ; k++) begin
        int nf;
        nf = $urandom_range(0, 2);
        for (int f = 0; f < nf; f++)
          add_frame(k, $urandom_range(1, 3), 24'($urandom), 1'b1);
      end
      model_batch();
      finish_batch("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
